// File: rtl/apb_arb_master_pkg.sv
// Shared definitions for the two-requester APB master: FSM states and default sizing.
package apb_arb_master_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 2;
    localparam int unsigned DEF_DATA_WIDTH = 4;
    localparam int unsigned DEF_TIMEOUT    = 15;
    localparam int unsigned WAIT_W         = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: the requester that lost the last accepted grant wins a tie.
module apb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_prio;

    always_comb begin
        grant = 2'b00;
        if (req[r_prio]) begin
            grant[r_prio] = 1'b1;
        end else if (req[~r_prio]) begin
            grant[~r_prio] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (advance && (|grant)) begin
            r_prio <= ~grant[1];
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: round-robin grant, IDLE/SETUP/ACCESS sequencing,
// and a bounded ACCESS wait that aborts with an error pulse.
module apb_arb_master
    import apb_arb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    pclk,
    input  logic                    prst_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_done,
    output logic [1:0]              req_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    output logic                    busy
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    apb_state_e              r_state, w_state_d;
    logic [WAIT_W-1:0]       r_wait, w_wait_d;
    logic [1:0]              r_done, w_done_d;
    logic [1:0]              r_err, w_err_d;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_d;
    logic                    r_gnt;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic [1:0]              w_req;
    logic [1:0]              w_grant;
    logic                    w_start;
    logic                    w_gnt_idx;

    // A requester sees req_done one cycle late, so mask it here to avoid a second grant.
    assign w_req     = req_valid & ~r_done;
    assign w_start   = (r_state == StIdle) && (|w_req);
    assign w_gnt_idx = w_grant[1];

    apb_rr_arb2 u_arb (
        .clk     (pclk),
        .rst_n   (prst_n),
        .req     (w_req),
        .advance (w_start),
        .grant   (w_grant)
    );

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait;
        w_done_d  = 2'b00;
        w_err_d   = 2'b00;
        w_rdata_d = r_rdata;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                w_state_d = StAccess;
                w_wait_d  = '0;
            end
            StAccess: begin
                if (pready) begin
                    w_state_d       = StIdle;
                    w_done_d[r_gnt] = 1'b1;
                    if (!r_write) begin
                        w_rdata_d = prdata;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_state_d       = StIdle;
                    w_done_d[r_gnt] = 1'b1;
                    w_err_d[r_gnt]  = 1'b1;
                end else begin
                    w_wait_d = r_wait + WAIT_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= StIdle;
            r_wait  <= '0;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            r_wait  <= w_wait_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
            r_rdata <= w_rdata_d;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_gnt   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_gnt   <= w_gnt_idx;
            r_write <= w_gnt_idx ? req_write[1] : req_write[0];
            r_addr  <= w_gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : req_addr[ADDR_WIDTH-1:0];
            r_wdata <= w_gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : req_wdata[DATA_WIDTH-1:0];
        end
    end

    assign psel      = (r_state != StIdle);
    assign penable   = (r_state == StAccess);
    assign busy      = (r_state != StIdle);
    assign pwrite    = r_write;
    assign paddr     = r_addr;
    assign pwdata    = r_wdata;
    assign req_done  = r_done;
    assign req_err   = r_err;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: table of single transfers plus contention and reset cases.
module tb_apb_arb_master;

    logic       pclk = 1'b0;
    logic       prst_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_write = 2'b00;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic [1:0] req_done, req_err;
    logic [3:0] rsp_rdata;
    logic       psel, penable, pwrite, busy;
    logic [1:0] paddr;
    logic [3:0] pwdata;
    logic       pready;
    logic [3:0] prdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model: 4-entry memory, pready after ready_after ACCESS cycles (0 = never).
    logic [3:0] mem [4];
    int         ready_after = 1;
    int         acc_cnt = 0;

    assign pready = psel && penable && (ready_after != 0) && (acc_cnt == ready_after - 1);
    assign prdata = mem[paddr];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    always #5 pclk = ~pclk;

    apb_arb_master dut (
        .pclk      (pclk),
        .prst_n    (prst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .rsp_rdata (rsp_rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         req;
        logic       wr;
        logic [1:0] addr;
        logic [3:0] wdata;
        int         ready_after;
        logic [1:0] exp_done;
        logic [1:0] exp_err;
        logic [3:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // Drive one requester (other slices hold inverted junk) and check the whole transfer.
    task automatic run_vec(input vec_t v, input string tag);
        int  cyc = 0;
        int  acc = 0;
        bit  got = 0;
        bit  stable = 1;
        int  exp_acc;
        ready_after = v.ready_after;
        exp_acc = (v.ready_after == 0) ? 15 : v.ready_after;
        req_valid = (v.req == 0) ? 2'b01 : 2'b10;
        req_write = {v.wr, v.wr};
        req_addr  = (v.req == 0) ? {~v.addr, v.addr} : {v.addr, ~v.addr};
        req_wdata = (v.req == 0) ? {~v.wdata, v.wdata} : {v.wdata, ~v.wdata};
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge pclk); #1;
            cyc++;
            if (psel && penable) acc++;
            if (psel && (paddr !== v.addr || pwrite !== v.wr || pwdata !== v.wdata)) stable = 0;
            if (req_done != 2'b00) got = 1;
        end
        chk({tag, " completed"}, 32'(got), 32'd1);
        chk({tag, " req_done"}, 32'(req_done), 32'(v.exp_done));
        chk({tag, " req_err"}, 32'(req_err), 32'(v.exp_err));
        chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
        chk({tag, " cycles"}, 32'(cyc), 32'(exp_acc + 2));
        chk({tag, " access cycles"}, 32'(acc), 32'(exp_acc));
        chk({tag, " bus stable"}, 32'(stable), 32'd1);
        chk({tag, " psel at done"}, 32'(psel), 32'd0);
        // Requester still holds req_valid for the done cycle; it must not be re-granted.
        @(posedge pclk); #1;
        chk({tag, " done pulse"}, 32'(req_done), 32'd0);
        chk({tag, " no regrant"}, 32'(busy), 32'd0);
        req_valid = 2'b00;
        @(posedge pclk); #1;
    endtask

    initial begin
        logic [1:0] order [4];
        int         when  [4];
        int         n_done;
        int         cyc;
        bit         seen;
        logic [1:0] exp_order [4];
        vec_t       post;

        mem[0] = 4'h3; mem[1] = 4'h6; mem[2] = 4'h9; mem[3] = 4'hC;

        //          req wr    addr   wdata  ra exp_done exp_err rdata
        vecs[0] = '{0, 1'b1, 2'd2, 4'hA, 2, 2'b01, 2'b00, 4'h0};
        vecs[1] = '{1, 1'b0, 2'd2, 4'h0, 2, 2'b10, 2'b00, 4'hA};
        vecs[2] = '{1, 1'b1, 2'd1, 4'h5, 1, 2'b10, 2'b00, 4'hA};
        vecs[3] = '{0, 1'b0, 2'd1, 4'h0, 3, 2'b01, 2'b00, 4'h5};
        vecs[4] = '{0, 1'b1, 2'd3, 4'hF, 0, 2'b01, 2'b01, 4'h5};
        vecs[5] = '{1, 1'b0, 2'd0, 4'h0, 0, 2'b10, 2'b10, 4'h5};
        vecs[6] = '{1, 1'b0, 2'd3, 4'h0, 1, 2'b10, 2'b00, 4'hC};

        // Reset state, with a request pending to show reset dominates.
        req_valid = 2'b11;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst psel", 32'(psel), 32'd0);
        chk("rst penable", 32'(penable), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst req_done", 32'(req_done), 32'd0);
        chk("rst req_err", 32'(req_err), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst pbus", 32'({pwrite, paddr, pwdata}), 32'd0);
        req_valid = 2'b00;
        prst_n = 1'b1;
        @(posedge pclk); #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        chk("mem[2] after write", 32'(mem[2]), 32'hA);
        chk("mem[1] after write", 32'(mem[1]), 32'h5);
        chk("mem[3] untouched by timeout", 32'(mem[3]), 32'hC);

        // Contention: both hold requests; last table grant was requester 1.
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        ready_after = 1;
        req_write = 2'b00;
        req_addr  = {2'd1, 2'd0};
        req_valid = 2'b11;
        n_done = 0;
        cyc = 0;
        for (int k = 0; k < 40 && n_done < 4; k++) begin
            @(posedge pclk); #1;
            cyc++;
            if (req_done != 2'b00) begin
                order[n_done] = req_done;
                when[n_done]  = cyc;
                n_done++;
                if (n_done == 4) req_valid = 2'b00;
            end
        end
        chk("contention completions", 32'(n_done), 32'd4);
        for (int i = 0; i < n_done; i++) begin
            chk($sformatf("contention grant %0d", i), 32'(order[i]), 32'(exp_order[i]));
            if (i > 0) chk($sformatf("contention spacing %0d", i),
                           32'(when[i] - when[i-1] >= 3), 32'd1);
        end
        repeat (2) @(posedge pclk);
        #1;
        chk("contention idle", 32'(busy), 32'd0);

        // Reset in the middle of ACCESS.
        ready_after = 0;
        req_write = 2'b01;
        req_addr  = {2'd3, 2'd0};
        req_wdata = {4'h1, 4'h7};
        req_valid = 2'b01;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge pclk); #1;
            if (penable) seen = 1;
        end
        chk("reach ACCESS", 32'(seen), 32'd1);
        repeat (2) @(posedge pclk);
        #3;
        prst_n = 1'b0;
        #1;
        chk("async rst psel", 32'(psel), 32'd0);
        chk("async rst penable", 32'(penable), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (2) begin
            @(posedge pclk); #1;
            if (req_done != 2'b00) seen = 1;
        end
        chk("no done in reset", 32'(seen), 32'd0);
        prst_n = 1'b1;
        req_valid = 2'b00;
        @(posedge pclk); #1;

        post = '{0, 1'b1, 2'd0, 4'h7, 1, 2'b01, 2'b00, 4'h0};
        run_vec(post, "post reset");
        chk("mem[0] after post reset write", 32'(mem[0]), 32'h7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter: ADDR_WIDTH, default 2, APB address width.
REQ-002 Parameter: DATA_WIDTH, default 4, APB data width.
REQ-003 Parameter: TIMEOUT, default 15, maximum ACCESS cycles before abort; legal range 2..255.
REQ-004 Port: pclk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: prst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port: req_valid  in  2  bit i = requester i holds a pending transfer.
REQ-007 Port: req_write  in  2  bit i = requester i transfer is a write (1) or read (0).
REQ-008 Port: req_addr  in  2*ADDR_WIDTH  slice i = requester i address.
REQ-009 Port: req_wdata  in  2*DATA_WIDTH  slice i = requester i write data.
REQ-010 Port: req_done  out  2  one-cycle pulse on bit i when requester i's transfer ends.
REQ-011 Port: req_err  out  2  one-cycle pulse on bit i, coincident with req_done[i], on timeout abort.
REQ-012 Port: rsp_rdata  out  DATA_WIDTH  read data, valid in the cycle req_done pulses for a read.
REQ-013 Port: psel, penable, pwrite  out  1 each  APB control to the slave.
REQ-014 Port: paddr  out  ADDR_WIDTH; pwdata  out  DATA_WIDTH  APB address and write data.
REQ-015 Port: pready  in  1; prdata  in  DATA_WIDTH  APB slave response.
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-018 IDLE: if any req_valid bit is set, grant one requester, latch its write, addr and wdata, and go to SETUP; otherwise remain in IDLE.
REQ-019 Arbitration: round-robin; the requester that did not win the last grant has priority; after reset requester 0 has priority.
REQ-020 SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
REQ-021 ACCESS: psel=1, penable=1; pready is sampled only in ACCESS and is ignored in IDLE and SETUP.
REQ-022 ACCESS with pready=1: pulse req_done[grant]; for a read, register prdata into rsp_rdata in that cycle; return to IDLE.
REQ-023 ACCESS timeout: a wait counter clears on entry to ACCESS; when it reaches TIMEOUT with pready still 0, pulse req_done[grant] and req_err[grant], leave rsp_rdata unchanged, and return to IDLE.
REQ-024 paddr, pwrite and pwdata SHALL be driven from the latched values and stay stable from SETUP through the end of ACCESS.
REQ-025 Requesters SHALL hold req_valid until their req_done; the block never grants the same requester twice for one request.
REQ-026 IDLE SHALL be held for at least one cycle between transfers, giving a minimum of 3 cycles per transfer (IDLE, SETUP, ACCESS).
REQ-027 In IDLE, psel and penable SHALL be 0; a requester dropping req_valid mid-transfer has no effect on the transfer.

Reset
REQ-028 While prst_n=0: state IDLE; psel, penable, pwrite, paddr, pwdata, req_done, req_err, rsp_rdata and busy all 0; round-robin pointer set to requester 0; wait counter 0.
REQ-029 Reset asserted mid-transfer SHALL abort immediately with no req_done pulse; after release, the first IDLE cycle arbitrates afresh.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default width and TIMEOUT constants.
REQ-031 The round-robin arbiter SHALL be a separate sub-module, apb_rr_arb2 (inputs: req[1:0] and advance; output: one-hot grant); all other logic stays in apb_arb_master.

Verification
REQ-032 Single write: req_valid=01, write=1, addr=2, wdata=0xA, with a slave that asserts pready on the 2nd ACCESS cycle -> SETUP then 2 ACCESS cycles, req_done=01, slave mem[2]=0xA.
REQ-033 Read-back: requester 1 reads addr=2 after REQ-032 -> req_done=10 and rsp_rdata=0xA in the same cycle.
REQ-034 Contention: req_valid=11 held continuously -> grants alternate 0,1,0,1, and each transfer spans at least 3 cycles.
REQ-035 Timeout: pready tied 0, TIMEOUT=15 -> ACCESS lasts exactly 15 cycles, then req_done and req_err pulse together and psel drops.
REQ-036 Reset mid-ACCESS: prst_n=0 during ACCESS -> psel, penable and busy go to 0 asynchronously with no req_done; after release, the next request completes normally.
